// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // The length prefix is a little-endian byte count of this many bytes.
    localparam int LEN_BYTES  = 2;
    localparam int LEN_WIDTH  = LEN_BYTES * 8;
    localparam int CSUM_WIDTH = 8;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input handshake and instruction-memory write port of the boot loader.
// The master side is the host byte source/memory observer, the slave side is the loader.
interface imem_boot_loader_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
);

    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives LEN_LO, LEN_HI, then N payload bytes and writes them to
// instruction memory from address 0, holding the CPU in reset until the load completes.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte and a CHECK state.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus,
    input  logic              reload,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned CAPACITY = 2 ** ADDRESS_WIDTH;

    state_t               state;
    state_t               next_state;
    logic                 ready_en;
    logic                 in_ready;
    logic                 xfer;
    logic [7:0]           len_lo;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] len_now;
    logic [LEN_WIDTH-1:0] cnt;
    state_t               after_load;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CSUM_WIDTH-1:0] csum;
    assign after_load = S_CHECK;
`else
    assign after_load = S_DONE;
`endif

    // ready_en keeps in_ready low while reset is held and for the first cycle after it.
    assign in_ready     = ready_en && (state != S_DONE) && (state != S_ERROR);
    assign bus.in_ready = in_ready;
    assign xfer         = bus.in_valid && in_ready;
    assign len_now      = {bus.in_data, len_lo};
    assign done         = (state == S_DONE);
    assign error        = (state == S_ERROR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LEN_LO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one byte consumed per transfer; reload only leaves DONE/ERROR.
    always_comb begin
        next_state = state;
        case (state)
            S_LEN_LO: begin
                if (xfer) begin
                    next_state = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_now == '0) begin
                        next_state = after_load;
                    end else if (32'(len_now) > CAPACITY) begin
                        next_state = S_ERROR;
                    end else begin
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer && (cnt == len - 1'b1)) begin
                    next_state = after_load;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    next_state = (bus.in_data == csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (reload) begin
                    next_state = S_LEN_LO;
                end
            end
            default: next_state = S_LEN_LO;
        endcase
    end

    // Length capture, byte counter and the registered memory write (one cycle after acceptance).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en    <= 1'b0;
            len_lo      <= '0;
            len         <= '0;
            cnt         <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            ready_en  <= 1'b1;
            bus.wr_en <= 1'b0;
            if (xfer) begin
                case (state)
                    S_LEN_LO: len_lo <= bus.in_data;
                    S_LEN_HI: begin
                        len <= len_now;
                        cnt <= '0;
                    end
                    S_LOAD: begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= cnt[ADDRESS_WIDTH-1:0];
                        bus.wr_data <= DATA_WIDTH'(bus.in_data);
                        cnt         <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // CPU is released one cycle after DONE is entered, and re-held on the reload edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_hold <= 1'b1;
        end else begin
            cpu_hold <= !((state == S_DONE) && !reload);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running modulo-256 sum of payload bytes, restarted when the length is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (xfer && (state == S_LEN_HI)) begin
            csum <= '0;
        end else if (xfer && (state == S_LOAD)) begin
            csum <= csum + bus.in_data;
        end
    end
`endif

endmodule
